// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment encodings, digit selects and FSM state shared by the display encoder and decoder
package seven_seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] DIG0 = 4'b1110;
  localparam logic [3:0] DIG1 = 4'b1101;
  localparam logic [3:0] DIG2 = 4'b1011;
  localparam logic [3:0] DIG3 = 4'b0111;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction
  function automatic logic dig_valid(input logic [3:0] d);
    return d inside {DIG0, DIG1, DIG2, DIG3};
  endfunction
  function automatic logic [1:0] dig_index(input logic [3:0] d);
    return d == DIG1 ? 2'd1 : d == DIG2 ? 2'd2 : d == DIG3 ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: decodes a segment pattern back to its hex nibble, flagging blank and unrecognized patterns
module seg7_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       bad
);
  // Searching the encoder's own table keeps encode and decode from drifting apart.
  always_comb begin
    nibble = 4'h0;
    blank = seg == SEG_BLANK;
    bad = seg != SEG_BLANK;
    for (int i = 0; i < 16; i++)
      if (seg == hex_to_seg(4'(i))) begin
        nibble = 4'(i);
        bad = 1'b0;
      end
  end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuilds the 16-bit hex value shown on a multiplexed four-digit seven-segment bus
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  digits,
  output logic [15:0] value,
  output logic [3:0]  blank_mask,
  output logic        value_valid,
  output logic        frame_done,
  output logic        frame_error
);
  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  logic [10:0] s_q, s_d;
  logic [7:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic [3:0] seen_q, seen_d, fblank_q, fblank_d, blank_q, blank_d;
  logic [15:0] frame_q, frame_d, value_q, value_d;
  logic err_q, err_d, valid_q, valid_d, done_q, done_d, ferr_q, ferr_d;
  logic chg, sel_ok, smp, complete, nib_blank, nib_bad;
  logic [1:0] idx;
  logic [3:0] nib;

  seg7_to_hex u_dec (
    .seg    (s_q[6:0]),
    .nibble (nib),
    .blank  (nib_blank),
    .bad    (nib_bad)
  );

  // A change landing on the capture edge restarts the count, so it wins over the sample.
  always_comb begin
    s_d = {digits, seg};
    chg = s_d != s_q;
    cnt_d = chg ? 8'd1 : cnt_q >= SETTLE ? cnt_q : cnt_q + 8'd1;
    sel_ok = dig_valid(s_q[10:7]);
    idx = dig_index(s_q[10:7]);
  end

  always_comb begin
    state_d = state_q;
    smp = 1'b0;
    if (chg)
      state_d = dig_valid(s_d[10:7]) ? ST_SETTLE : ST_IDLE;
    else
      case (state_q)
        ST_IDLE: state_d = sel_ok ? ST_SETTLE : ST_IDLE;
        ST_SETTLE: begin
          smp = sel_ok && cnt_q >= SETTLE;
          state_d = !sel_ok ? ST_IDLE : smp ? ST_CAPTURE : ST_SETTLE;
        end
        ST_CAPTURE: state_d = sel_ok ? ST_CAPTURE : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
  end

  // Completion publishes the registered frame while a same-cycle sample seeds the next one.
  always_comb begin
    complete = seen_q == 4'hF;
    seen_d = (complete ? 4'h0 : seen_q) | (smp ? 4'b0001 << idx : 4'h0);
    err_d = (complete ? 1'b0 : err_q) | (smp & nib_bad);
    frame_d = frame_q;
    fblank_d = fblank_q;
    if (smp) begin
      frame_d[{idx, 2'b00} +: 4] = nib;
      fblank_d[idx] = nib_blank;
    end
    value_d = complete && !err_q ? frame_q : value_q;
    blank_d = complete && !err_q ? fblank_q : blank_q;
    valid_d = valid_q | (complete & !err_q);
    done_d = complete;
    ferr_d = complete & err_q;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      s_q <= '0;
      cnt_q <= '0;
      state_q <= ST_IDLE;
      seen_q <= '0;
      err_q <= 1'b0;
      frame_q <= '0;
      fblank_q <= '0;
      value_q <= '0;
      blank_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s_q <= s_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      seen_q <= seen_d;
      err_q <= err_d;
      frame_q <= frame_d;
      fblank_q <= fblank_d;
      value_q <= value_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
    end

  assign value = value_q;
  assign blank_mask = blank_q;
  assign value_valid = valid_q;
  assign frame_done = done_q;
  assign frame_error = ferr_q;
endmodule
